vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel/line counters with registered sync, blank and
// data-enable outputs, line/frame start pulses and a completed-frame counter.
// All decoded outputs are computed from the next-state counts so they are
// registered in the same cycle as the counts they describe.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter bit H_POL     = 1'b0,
   parameter bit V_POL     = 1'b0,
   parameter int CW        = 11,
   parameter int FW        = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pix_en,
   input  logic          restart,
   output logic [CW-1:0] h_count,
   output logic [CW-1:0] v_count,
   output logic          hsync,
   output logic          vsync,
   output logic          hblank,
   output logic          vblank,
   output logic          de,
   output logic          line_start,
   output logic          frame_start,
   output logic [FW-1:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Window bounds held as 32-bit values so an end bound equal to 2^CW
   // (sync running to the last column) does not alias to zero.
   localparam logic [31:0] H_LAST   = 32'(H_TOTAL - 1);
   localparam logic [31:0] V_LAST   = 32'(V_TOTAL - 1);
   localparam logic [31:0] H_VIS    = 32'(H_VISIBLE);
   localparam logic [31:0] V_VIS    = 32'(V_VISIBLE);
   localparam logic [31:0] HS_START = 32'(H_VISIBLE + H_FRONT);
   localparam logic [31:0] HS_END   = 32'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [31:0] VS_START = 32'(V_VISIBLE + V_FRONT);
   localparam logic [31:0] VS_END   = 32'(V_VISIBLE + V_FRONT + V_SYNC);

   if (longint'(H_TOTAL) > (longint'(1) << CW)) begin : g_h_total_chk
      $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
   end
   if (longint'(V_TOTAL) > (longint'(1) << CW)) begin : g_v_total_chk
      $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
   end

   logic [CW-1:0] h_q, h_d;
   logic [CW-1:0] v_q, v_d;
   logic [FW-1:0] fc_q, fc_d;
   logic          restart_q;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          hblank_q, hblank_d;
   logic          vblank_q, vblank_d;
   logic          de_q, de_d;
   logic          ls_q, ls_d;
   logic          fs_q, fs_d;
   logic          restart_first;
   logic          h_end, v_end;
   logic [31:0]   h_nx, v_nx;

   // Next-state counters, pulses and decodes of the next counts.
   always_comb begin
      h_end         = (32'(h_q) == H_LAST);
      v_end         = (32'(v_q) == V_LAST);
      restart_first = restart & ~restart_q;
      h_d  = h_q;
      v_d  = v_q;
      fc_d = fc_q;
      ls_d = 1'b0;
      fs_d = 1'b0;
      if (restart) begin
         // Restart wins over pix_en; only its first cycle emits pulses.
         h_d  = '0;
         v_d  = '0;
         ls_d = restart_first;
         fs_d = restart_first;
      end else if (pix_en) begin
         if (h_end) begin
            h_d  = '0;
            ls_d = 1'b1;
            if (v_end) begin
               v_d  = '0;
               fc_d = fc_q + FW'(1);
               fs_d = 1'b1;
            end else begin
               v_d = v_q + CW'(1);
            end
         end else begin
            h_d = h_q + CW'(1);
         end
      end
      h_nx     = 32'(h_d);
      v_nx     = 32'(v_d);
      hsync_d  = ((h_nx >= HS_START) && (h_nx < HS_END)) ? H_POL : ~H_POL;
      vsync_d  = ((v_nx >= VS_START) && (v_nx < VS_END)) ? V_POL : ~V_POL;
      hblank_d = (h_nx >= H_VIS);
      vblank_d = (v_nx >= V_VIS);
      de_d     = ~hblank_d & ~vblank_d;
   end

   // State and registered outputs; reset forces the (0,0) idle picture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_q       <= '0;
         v_q       <= '0;
         fc_q      <= '0;
         restart_q <= 1'b0;
         hsync_q   <= ~H_POL;
         vsync_q   <= ~V_POL;
         hblank_q  <= 1'b0;
         vblank_q  <= 1'b0;
         de_q      <= 1'b1;
         ls_q      <= 1'b0;
         fs_q      <= 1'b0;
      end else begin
         h_q       <= h_d;
         v_q       <= v_d;
         fc_q      <= fc_d;
         restart_q <= restart;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         hblank_q  <= hblank_d;
         vblank_q  <= vblank_d;
         de_q      <= de_d;
         ls_q      <= ls_d;
         fs_q      <= fs_d;
      end
   end

   assign h_count     = h_q;
   assign v_count     = v_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign hblank      = hblank_q;
   assign vblank      = vblank_q;
   assign de          = de_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;
   assign frame_count = fc_q;

endmodule
